// File: rtl/multi_read_fifo_status_ctrl.sv
// ---------------------------------------------------------------------------
// multi_read_fifo_status_ctrl
//
// Watches the fill levels of CH read FIFOs. When a channel has room for a
// full burst, it requests a transfer from a downstream master. Channels are
// served round-robin. A channel flagged as a frame tail asks for its tail
// length instead of a full burst.
//
// Optional build macro: RD_REQ_TIMEOUT_EN
//   When this macro is defined, a watchdog aborts WAIT_DONE after TIMEOUT
//   cycles without done and pulses timeout_err. When it is undefined,
//   timeout_err is tied low and WAIT_DONE waits indefinitely.
//
// Ports
//   clock        single clock, all logic rising-edge
//   rst          asynchronous active-high reset
//   enable       per-channel request enable             [CH]
//   count        per-channel FIFO fill count            [CH*CWIDTH]
//   tail_status  per-channel "next request is a tail"   [CH]
//   tail_len     per-channel tail length                [CH*LSIZE]
//   burst_req    full-burst request, high during REQ
//   tail_req     tail request, high during REQ
//   req_ch       granted channel                        [CH_W]
//   req_len      requested length                       [LSIZE]
//   resp         request accepted by downstream master
//   done         data transfer complete
//   busy         high whenever the FSM is not IDLE
//   timeout_err  one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module multi_read_fifo_status_ctrl #(
    parameter int CH        = 4,
    parameter int CWIDTH    = 9,
    parameter int FULL_LEN  = 256,
    parameter int THRESHOLD = 200,
    parameter int LSIZE     = 9,
    parameter int TIMEOUT   = 1024,
    parameter int CH_W      = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [CH-1:0]         enable,
    input  logic [CH*CWIDTH-1:0]  count,
    input  logic [CH-1:0]         tail_status,
    input  logic [CH*LSIZE-1:0]   tail_len,
    output logic                  burst_req,
    output logic                  tail_req,
    output logic [CH_W-1:0]       req_ch,
    output logic [LSIZE-1:0]      req_len,
    input  logic                  resp,
    input  logic                  done,
    output logic                  busy,
    output logic                  timeout_err
);

    // The comparison must be wide enough for both the count and FULL_LEN.
    localparam int CMPW = (CWIDTH > $clog2(FULL_LEN) + 1) ? CWIDTH : $clog2(FULL_LEN) + 1;
    localparam logic [CMPW-1:0] ROOM = CMPW'(FULL_LEN - THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DONE,
        S_FSH
    } state_t;

    state_t            state_q;
    logic [CH-1:0]     trig_q, trig_d;
    logic [CH-1:0]     elig;
    logic [CH_W-1:0]   last_grant_q;
    logic [CH_W-1:0]   req_ch_q;
    logic [LSIZE-1:0]  req_len_q;
    logic              burst_req_q, tail_req_q, busy_q;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;

`ifdef RD_REQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]    wdog_q;
    logic              timeout_err_q;
`endif

    // Trigger and eligibility. A tail request of length zero is never issued.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        trig_d = '0;
        elig   = '0;
        for (int i = 0; i < CH; i++) begin
            trig_d[i] = enable[i] && (ROOM > CMPW'(count[i*CWIDTH +: CWIDTH]));
            elig[i]   = trig_q[i] && !(tail_status[i] && (tail_len[i*LSIZE +: LSIZE] == '0));
        end
    end

    // Round-robin search that starts one past the last granted channel.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < CH; k++) begin
            idx = (int'(last_grant_q) + 1 + k) % CH;
            if (!grant_found && elig[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            trig_q        <= '0;
            burst_req_q   <= 1'b0;
            tail_req_q    <= 1'b0;
            req_ch_q      <= '0;
            req_len_q     <= '0;
            busy_q        <= 1'b0;
            last_grant_q  <= CH_W'(CH - 1);
`ifdef RD_REQ_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            trig_q <= trig_d;
`ifdef RD_REQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        state_q  <= S_REQ;
                        busy_q   <= 1'b1;
                        req_ch_q <= grant_idx;
                        if (tail_status[grant_idx]) begin
                            tail_req_q <= 1'b1;
                            req_len_q  <= tail_len[grant_idx*LSIZE +: LSIZE];
                        end else begin
                            burst_req_q <= 1'b1;
                            req_len_q   <= LSIZE'(THRESHOLD);
                        end
                    end
                end
                S_REQ: begin
                    if (resp) begin
                        burst_req_q <= 1'b0;
                        tail_req_q  <= 1'b0;
                        if (done) begin
                            state_q      <= S_FSH;
                            last_grant_q <= req_ch_q;
                        end else begin
                            state_q <= S_WAIT_DONE;
`ifdef RD_REQ_TIMEOUT_EN
                            wdog_q  <= '0;
`endif
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        state_q      <= S_FSH;
                        last_grant_q <= req_ch_q;
`ifdef RD_REQ_TIMEOUT_EN
                    end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        // TIMEOUT-th WAIT_DONE cycle without done: give up.
                        state_q       <= S_FSH;
                        last_grant_q  <= req_ch_q;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
`endif
                    end
                end
                S_FSH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign burst_req = burst_req_q;
    assign tail_req  = tail_req_q;
    assign req_ch    = req_ch_q;
    assign req_len   = req_len_q;
    assign busy      = busy_q;
`ifdef RD_REQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_read_fifo_status_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for multi_read_fifo_status_ctrl (CH=4, CWIDTH=9, FULL_LEN=256,
// THRESHOLD=200, LSIZE=9, TIMEOUT=16). Directed scenarios plus a randomized
// transaction loop checked against a transaction-level arbitration model.
// ---------------------------------------------------------------------------
module tb_multi_read_fifo_status_ctrl;

    localparam int CH        = 4;
    localparam int CWIDTH    = 9;
    localparam int FULL_LEN  = 256;
    localparam int THRESHOLD = 200;
    localparam int LSIZE     = 9;
    localparam int ROOM      = FULL_LEN - THRESHOLD;

    logic                 clock = 1'b0;
    logic                 rst   = 1'b1;
    logic [CH-1:0]        enable      = '0;
    logic [CH*CWIDTH-1:0] count;
    logic [CH-1:0]        tail_status = '0;
    logic [CH*LSIZE-1:0]  tail_len;
    logic                 burst_req, tail_req;
    logic [1:0]           req_ch;
    logic [LSIZE-1:0]     req_len;
    logic                 resp = 1'b0;
    logic                 done = 1'b0;
    logic                 busy, timeout_err;

    logic [CWIDTH-1:0]    cnt_v [CH];
    logic [LSIZE-1:0]     tl_v  [CH];

    int n_checks = 0;
    int n_pass   = 0;
    int model_last;

    for (genvar g = 0; g < CH; g++) begin : g_pack
        assign count[g*CWIDTH +: CWIDTH]  = cnt_v[g];
        assign tail_len[g*LSIZE +: LSIZE] = tl_v[g];
    end

    always #5 clock = ~clock;

    multi_read_fifo_status_ctrl #(
        .CH(CH), .CWIDTH(CWIDTH), .FULL_LEN(FULL_LEN), .THRESHOLD(THRESHOLD),
        .LSIZE(LSIZE), .TIMEOUT(16), .CH_W(2)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable), .count(count),
        .tail_status(tail_status), .tail_len(tail_len),
        .burst_req(burst_req), .tail_req(tail_req), .req_ch(req_ch),
        .req_len(req_len), .resp(resp), .done(done), .busy(busy),
        .timeout_err(timeout_err)
    );

    // Reference: the eligible channel closest after the last grant, cyclically.
    function automatic int model_grant(input int last);
        int best, bestd, d;
        best  = -1;
        bestd = CH;
        for (int i = 0; i < CH; i++) begin
            if (enable[i] && int'(cnt_v[i]) < ROOM && !(tail_status[i] && tl_v[i] == '0)) begin
                d = (i - last - 1 + 2 * CH) % CH;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        rst = 1'b1;
        enable = '0; tail_status = '0; resp = 1'b0; done = 1'b0;
        for (int i = 0; i < CH; i++) begin
            cnt_v[i] = '0;
            tl_v[i]  = '0;
        end
        repeat (2) @(negedge clock);
        rst = 1'b0;
        model_last = CH - 1;
    endtask

    // Waits up to maxc falling edges for a request; lat = edges waited.
    task automatic wait_req(input int maxc, output int lat, output bit found);
        found = 1'b0;
        lat   = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clock);
            if (burst_req || tail_req) begin
                found = 1'b1;
                lat   = i;
                break;
            end
        end
    endtask

    // Called at a falling edge while in REQ; completes the handshake.
    task automatic finish_txn(input bit same_cycle, output bit ok);
        resp = 1'b1;
        done = same_cycle;
        @(negedge clock);
        resp = 1'b0;
        done = 1'b0;
        if (!same_cycle) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            done = 1'b1;
            @(negedge clock);
            done = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({burst_req, tail_req, req_ch, req_len, busy, timeout_err} !== '0)
            $display("FAIL reset_outputs: got %b required 0",
                     {burst_req, tail_req, req_ch, req_len, busy, timeout_err});
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_basic_burst();
        int lat; bit found, ok;
        apply_reset();
        cnt_v[0] = 9'd10;
        enable   = 4'b0001;
        wait_req(6, lat, found);
        n_checks++;
        if (!found || lat != 2) $display("FAIL basic_latency: got found=%0d lat=%0d required lat=2", found, lat);
        else n_pass++;
        n_checks++;
        if (req_ch !== 2'd0 || req_len !== 9'd200)
            $display("FAIL basic_fields: got ch=%0d len=%0d required ch=0 len=200", req_ch, req_len);
        else n_pass++;
        n_checks++;
        if ({burst_req, tail_req, busy} !== 3'b101)
            $display("FAIL basic_kind: got burst/tail/busy=%b required 101", {burst_req, tail_req, busy});
        else n_pass++;
        enable = '0;
        resp   = 1'b1;
        @(negedge clock);
        resp = 1'b0;
        n_checks++;
        if ({burst_req, busy} !== 2'b01)
            $display("FAIL basic_after_resp: got burst/busy=%b required 01", {burst_req, busy});
        else n_pass++;
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL basic_fsh_busy: got %b required 1", busy);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if (req_ch !== 2'd0 || req_len !== 9'd200)
            $display("FAIL basic_hold: got ch=%0d len=%0d required ch=0 len=200", req_ch, req_len);
        else n_pass++;
        // resp/done while idle must not start anything.
        resp = 1'b1; done = 1'b1;
        @(negedge clock);
        resp = 1'b0; done = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({burst_req, tail_req, busy} !== 3'b000)
            $display("FAIL idle_resp_ignored: got %b required 000", {burst_req, tail_req, busy});
        else n_pass++;
    endtask

    task automatic test_threshold();
        int lat; bit found, ok;
        apply_reset();
        cnt_v[0] = 9'd56;
        enable   = 4'b0001;
        wait_req(10, lat, found);
        n_checks++;
        if (found) $display("FAIL thresh_56: got request required none");
        else n_pass++;
        cnt_v[0] = 9'd55;
        wait_req(6, lat, found);
        n_checks++;
        if (!found || lat != 2) $display("FAIL thresh_55: got found=%0d lat=%0d required lat=2", found, lat);
        else n_pass++;
        enable = '0;
        finish_txn(1'b0, ok);
        n_checks++;
        if (!ok) $display("FAIL thresh_finish: got busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic rr_run(input logic [3:0] en, input int n, input string tag);
        int lat, exp_ch; bit found;
        apply_reset();
        enable = en;
        for (int t = 0; t < n; t++) begin
            exp_ch = model_grant(model_last);
            wait_req(8, lat, found);
            n_checks++;
            if (!found || int'(req_ch) != exp_ch)
                $display("FAIL %s_seq%0d: got found=%0d ch=%0d required ch=%0d", tag, t, found, req_ch, exp_ch);
            else n_pass++;
            resp = 1'b1; done = 1'b1;
            @(negedge clock);
            resp = 1'b0; done = 1'b0;
            model_last = exp_ch;
        end
        enable = '0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_round_robin();
        rr_run(4'b1111, 5, "rr_all");
        rr_run(4'b1010, 3, "rr_1010");
    endtask

    task automatic test_tail();
        int lat; bit found, ok;
        apply_reset();
        enable = 4'b0100;
        tail_status[2] = 1'b1;
        tl_v[2] = 9'd37;
        wait_req(6, lat, found);
        n_checks++;
        if (!found || {burst_req, tail_req} !== 2'b01 || req_ch !== 2'd2 || req_len !== 9'd37)
            $display("FAIL tail_req: got found=%0d b/t=%b ch=%0d len=%0d required b/t=01 ch=2 len=37",
                     found, {burst_req, tail_req}, req_ch, req_len);
        else n_pass++;
        finish_txn(1'b1, ok);
        tl_v[2] = '0;
        enable  = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            wait_req(8, lat, found);
            n_checks++;
            if (!found || req_ch !== 2'd0)
                $display("FAIL tail_zero%0d: got found=%0d ch=%0d required ch=0", t, found, req_ch);
            else n_pass++;
            finish_txn(1'b1, ok);
        end
        enable = '0;
        tail_status = '0;
    endtask

    task automatic test_simultaneous();
        int lat; bit found;
        apply_reset();
        enable = 4'b0001;
        wait_req(6, lat, found);
        enable = '0;
        resp = 1'b1; done = 1'b1;
        @(negedge clock);
        resp = 1'b0; done = 1'b0;
        n_checks++;
        if ({found, burst_req, tail_req, busy} !== 4'b1001)
            $display("FAIL simul_fsh: got found/b/t/busy=%b required 1001", {found, burst_req, tail_req, busy});
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL simul_idle: got busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; bit found, ok;
        apply_reset();
        enable = 4'b0010;
        wait_req(6, lat, found);
        finish_txn(1'b1, ok);
        enable = 4'b0100;
        wait_req(8, lat, found);
        resp = 1'b1;
        @(negedge clock);
        resp = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({burst_req, tail_req, req_ch, req_len, busy, timeout_err} !== '0)
            $display("FAIL reset_mid: got %b required 0",
                     {burst_req, tail_req, req_ch, req_len, busy, timeout_err});
        else n_pass++;
        enable = 4'b1111;
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        wait_req(8, lat, found);
        n_checks++;
        if (!found || req_ch !== 2'd0)
            $display("FAIL reset_regrant: got found=%0d ch=%0d required ch=0", found, req_ch);
        else n_pass++;
        enable = '0;
        finish_txn(1'b1, ok);
    endtask

    task automatic test_watchdog();
        int lat, seen_at; bit found, ok;
        apply_reset();
        enable = 4'b0001;
        wait_req(6, lat, found);
        enable = '0;
        resp = 1'b1;
        seen_at = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clock);
            if (j == 1) resp = 1'b0;
            if (timeout_err) begin
                seen_at = j - 1;
                break;
            end
        end
`ifdef RD_REQ_TIMEOUT_EN
        n_checks++;
        if (seen_at != 16) $display("FAIL wdog_pulse: got %0d cycles required 16", seen_at);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({busy, timeout_err} !== 2'b00)
            $display("FAIL wdog_idle: got busy/err=%b required 00", {busy, timeout_err});
        else n_pass++;
`else
        n_checks++;
        if (seen_at != -1 || busy !== 1'b1)
            $display("FAIL wdog_off: got err_at=%0d busy=%b required none and busy=1", seen_at, busy);
        else n_pass++;
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL wdog_off_done: got busy=%b required 0", busy);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        int lat, exp_ch; bit found, ok;
        logic [LSIZE-1:0] exp_len;
        logic [1:0] exp_kind;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            enable = '0;
            repeat (2) @(negedge clock);
            for (int i = 0; i < CH; i++) begin
                cnt_v[i] = CWIDTH'($urandom_range(0, 80));
                tl_v[i]  = ($urandom_range(0, 2) == 0) ? '0 : LSIZE'($urandom_range(1, 511));
            end
            tail_status = 4'($urandom);
            enable      = 4'($urandom);
            exp_ch = model_grant(model_last);
            if (exp_ch < 0) begin
                wait_req(5, lat, found);
                n_checks++;
                if (found) $display("FAIL rand%0d_none: got ch=%0d required no request", t, req_ch);
                else n_pass++;
            end else begin
                exp_kind = tail_status[exp_ch] ? 2'b01 : 2'b10;
                exp_len  = tail_status[exp_ch] ? tl_v[exp_ch] : LSIZE'(THRESHOLD);
                wait_req(6, lat, found);
                n_checks++;
                if (!found || lat != 2 || int'(req_ch) != exp_ch || req_len !== exp_len ||
                    {burst_req, tail_req} !== exp_kind)
                    $display("FAIL rand%0d_grant: got f=%0d lat=%0d ch=%0d len=%0d bt=%b required lat=2 ch=%0d len=%0d bt=%b",
                             t, found, lat, req_ch, req_len, {burst_req, tail_req}, exp_ch, exp_len, exp_kind);
                else n_pass++;
                enable = '0;
                finish_txn(1'($urandom), ok);
                n_checks++;
                if (!ok) $display("FAIL rand%0d_finish: got busy=%b required 0", t, busy);
                else n_pass++;
                model_last = exp_ch;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            cnt_v[i] = '0;
            tl_v[i]  = '0;
        end
        test_reset();
        test_basic_burst();
        test_threshold();
        test_round_robin();
        test_tail();
        test_simultaneous();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/multi_read_fifo_status_ctrl.md
MULTI_READ_FIFO_STATUS_CTRL -- requirements
Module: multi_read_fifo_status_ctrl

Interface
REQ-001 SHALL have parameter CH, default 4, number of read-FIFO channels (1..8).
REQ-002 SHALL have parameter CWIDTH, default 9, per-channel FIFO count width.
REQ-003 SHALL have parameter FULL_LEN, default 256, FIFO depth in words.
REQ-004 SHALL have parameter THRESHOLD, default 200, burst length and empty threshold; THRESHOLD < FULL_LEN and THRESHOLD < 2^LSIZE.
REQ-005 SHALL have parameter LSIZE, default 9, request-length width.
REQ-006 SHALL have parameter TIMEOUT, default 1024, watchdog limit in cycles (macro builds only).
REQ-007 SHALL have parameter CH_W, default 2, width of req_ch, equal to max(1, clog2(CH)).
REQ-008 clock  in  1  single clock; all logic rising-edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 enable  in  CH  per-channel request enable.
REQ-011 count  in  CH*CWIDTH  per-channel FIFO fill count, channel i at bits [i*CWIDTH +: CWIDTH].
REQ-012 tail_status  in  CH  per-channel flag: the next request is a frame tail.
REQ-013 tail_len  in  CH*LSIZE  per-channel tail length, packed as count.
REQ-014 burst_req  out  1  full-burst request.
REQ-015 tail_req  out  1  tail request.
REQ-016 req_ch  out  CH_W  granted channel.
REQ-017 req_len  out  LSIZE  requested length.
REQ-018 resp  in  1  request accepted by the downstream master.
REQ-019 done  in  1  data transfer complete.
REQ-020 busy  out  1  high whenever the state is not IDLE.
REQ-021 timeout_err  out  1  one-cycle watchdog pulse.

Function
REQ-022 Trigger: trig[i] SHALL be registered as enable[i] && (FULL_LEN-THRESHOLD) > count_i, giving 1 cycle of latency; comparison SHALL be unsigned at max(CWIDTH, clog2(FULL_LEN)+1) bits.
REQ-023 A channel SHALL be eligible when trig[i]=1, excluding any channel with tail_status[i]=1 and tail_len_i=0.
REQ-024 The state machine SHALL have states IDLE, REQ, WAIT_DONE and FSH.
- IDLE→REQ on any eligible channel.
- REQ→WAIT_DONE on resp.
- REQ→FSH on resp&&done in the same cycle.
- WAIT_DONE→FSH on done.
- FSH→IDLE unconditionally.
REQ-025 Arbitration SHALL be round-robin: search starts at last_grant+1 (mod CH); last_grant resets to CH-1, so channel 0 wins first.
REQ-026 Leaving IDLE SHALL register req_ch, the request kind (tail if tail_status[ch]) and req_len (tail_len_ch for a tail, THRESHOLD otherwise), all in the same edge that enters REQ.
REQ-027 burst_req or tail_req (exactly one) SHALL be registered high throughout REQ and low in all other states; it falls the cycle after resp is sampled.
REQ-028 resp outside REQ and done outside REQ/WAIT_DONE SHALL be ignored.
REQ-029 req_ch and req_len SHALL hold their values until the next grant.
REQ-030 Deassertion of enable, or changes to count or tail_status, mid-transaction SHALL NOT abort the transaction.
REQ-031 last_grant SHALL update on entry to FSH.

Reset
REQ-032 rst SHALL force the following immediately, asynchronously: state=IDLE, trig=0, burst_req=0, tail_req=0, req_ch=0, req_len=0, busy=0, timeout_err=0, last_grant=CH-1, watchdog=0.
REQ-033 rst mid-transaction SHALL drop the request at once; the first post-reset grant is re-arbitrated from channel 0.

Configuration
REQ-034 Macro RD_REQ_TIMEOUT_EN SHALL control the watchdog.
- Defined: a counter clears on entering WAIT_DONE and increments each WAIT_DONE cycle; at TIMEOUT cycles without done, timeout_err pulses for 1 cycle and the state moves to FSH.
- Undefined: the counter is absent, timeout_err is tied to 0, and WAIT_DONE waits indefinitely.

Verification (CH=4, CWIDTH=9, FULL_LEN=256, THRESHOLD=200, LSIZE=9)
REQ-035 Basic burst:
- Stimulus: enable=0001, count0=10.
- Response: burst_req rises 2 cycles later with req_ch=0, req_len=200; resp → burst_req low the next cycle; done → FSH → IDLE, busy low.
REQ-036 Threshold boundary:
- count0=56 → no request ever.
- count0=55 → request issued.
REQ-037 Round-robin:
- Stimulus: all four channels triggering continuously, resp/done returned immediately.
- Response: req_ch sequence 0,1,2,3,0.
- Repeat with enable=1010: sequence 1,3,1.
REQ-038 Tail handling:
- ch2 tail_status=1, tail_len=37 → tail_req, req_ch=2, req_len=37.
- tail_len=0 → ch2 never granted.
REQ-039 Simultaneous events and reset:
- resp&&done in REQ → FSH the next cycle.
- rst asserted in WAIT_DONE → all outputs 0 immediately.
REQ-040 Watchdog, macro defined, TIMEOUT=16:
- Stimulus: done withheld.
- Response: timeout_err pulses 16 cycles after entry to WAIT_DONE, then IDLE.
- Undefined build: the state stays in WAIT_DONE.
